ep4_out_reader: RTL and testbench

Drains the USB EP4 OUT (bulk, host-to-device TS) endpoint buffer and pushes its bytes into the TS-from-USB FIFO feeding the CI path. It is the reader for the buffer the USB controller writes: it fetches each received packet byte by byte and honours FIFO back-pressure. It tracks 188-byte TS packet alignment across USB packets and re-arms the endpoint when done. Sits between usb2_top's EP4 OUT port and ts_proxy's ts_usb_* input.

---
 rtl/ep4_out_reader_if.sv | 24 ++
 rtl/ep4_out_reader.sv | 137 +++++++++++++
 tb/tb_ep4_out_reader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ep4_out_reader_if.sv
// EP4 OUT endpoint-buffer read port plus TS-from-USB FIFO write port.
// The master modport belongs to the reader; the slave modport belongs to
// the environment (USB core buffer and FIFO).
interface ep4_out_reader_if;
  logic        buf_out_hasdata;
  logic [9:0]  buf_out_len;
  logic [7:0]  buf_out_q;
  logic [10:0] buf_out_addr;
  logic        buf_out_arm;
  logic        buf_out_arm_ack;
  logic [7:0]  ts_usb_data;
  logic        ts_usb_writereq;
  logic        ts_usb_almost_full;

  modport master (
    input  buf_out_hasdata, buf_out_len, buf_out_q, buf_out_arm_ack, ts_usb_almost_full,
    output buf_out_addr, buf_out_arm, ts_usb_data, ts_usb_writereq
  );

  modport slave (
    output buf_out_hasdata, buf_out_len, buf_out_q, buf_out_arm_ack, ts_usb_almost_full,
    input  buf_out_addr, buf_out_arm, ts_usb_data, ts_usb_writereq
  );
endinterface

// File: rtl/ep4_out_reader.sv
// Drains the EP4 OUT endpoint buffer into the TS-from-USB FIFO, tracks
// 188-byte TS packet alignment across USB packets and re-arms the endpoint.
//
// state | meaning
// IDLE  | waiting for enable & buf_out_hasdata; latches the byte count
// FETCH | issuing one buffer read per cycle unless the FIFO is almost full
// DRAIN | all reads issued; waiting for the read pipeline to empty
// ARM   | buf_out_arm held high until the USB core acknowledges
module ep4_out_reader #(
  parameter int         READ_LATENCY = 2,
  parameter int         TS_PKT_LEN   = 188,
  parameter logic [7:0] SYNC_BYTE    = 8'h47
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  ep4_out_reader_if.master    bus,
  output logic                sync_locked,
  output logic [15:0]         sync_err_count,
  output logic [31:0]         byte_count
);

  localparam int             PW       = $clog2(TS_PKT_LEN);
  localparam logic [PW-1:0]  POS_LAST = PW'(TS_PKT_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_ARM} state_t;

  state_t                  state_q, state_d;
  logic [9:0]              len_q;
  logic [10:0]             addr_q;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic                    wreq_q;
  logic [7:0]              data_q;
  logic                    locked_q;
  logic [15:0]             err_q;
  logic [31:0]             cnt_q;
  logic [PW-1:0]           pos_q;

  logic issue, last_issue, emit, start;

  // State register; reset abandons any buffer in progress without arming it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and read-issue decision.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    start      = 1'b0;
    last_issue = (addr_q == ({1'b0, len_q} - 11'd1));
    unique case (state_q)
      S_IDLE: begin
        if (enable && bus.buf_out_hasdata) begin
          start   = 1'b1;
          state_d = (bus.buf_out_len == 10'd0) ? S_ARM : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!bus.ts_usb_almost_full) begin
          issue = 1'b1;
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_q == '0) state_d = S_ARM;
      end
      S_ARM: begin
        if (bus.buf_out_arm_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // One valid bit per issued read; the oldest bit marks buf_out_q as valid.
    vld_d = READ_LATENCY'({vld_q, issue});
    emit  = vld_q[READ_LATENCY-1];
  end

  // Read address, in-flight pipeline and FIFO write register.
  // The address on the bus is the next index to issue, so it is held while
  // the FIFO is almost full and bumped each time it is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q  <= '0;
      addr_q <= '0;
      vld_q  <= '0;
      wreq_q <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      wreq_q <= emit;
      if (emit) data_q <= bus.buf_out_q;
      if (start) begin
        len_q  <= bus.buf_out_len;
        addr_q <= '0;
      end else if (issue && !last_issue) begin
        addr_q <= addr_q + 11'd1;
      end
    end
  end

  // Byte counter and TS sync tracking on every byte written to the FIFO.
  // A bad byte at packet position 0 keeps the position at 0 so the next
  // byte is tried as a sync candidate (hunt).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      pos_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= '0;
    end else if (emit) begin
      cnt_q <= cnt_q + 32'd1;
      if (pos_q == '0) begin
        if (bus.buf_out_q == SYNC_BYTE) begin
          locked_q <= 1'b1;
          pos_q    <= PW'(1);
        end else begin
          locked_q <= 1'b0;
          if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
      end else if (pos_q == POS_LAST) begin
        pos_q <= '0;
      end else begin
        pos_q <= pos_q + PW'(1);
      end
    end
  end

  assign bus.buf_out_addr    = addr_q;
  assign bus.buf_out_arm     = (state_q == S_ARM);
  assign bus.ts_usb_data     = data_q;
  assign bus.ts_usb_writereq = wreq_q;
  assign sync_locked         = locked_q;
  assign sync_err_count      = err_q;
  assign byte_count          = cnt_q;

endmodule

// File: tb/tb_ep4_out_reader.sv
// Directed bench for ep4_out_reader: endpoint RAM model with a
// READ_LATENCY-stage read pipeline, USB-core arm/ack model and FIFO
// back-pressure driven from the scenario tasks.
module tb_ep4_out_reader;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sync_locked;
  logic [15:0] sync_err_count;
  logic [31:0] byte_count;

  ep4_out_reader_if bif ();

  ep4_out_reader #(.READ_LATENCY(RL), .TS_PKT_LEN(188), .SYNC_BYTE(8'h47)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bif),
    .sync_locked(sync_locked), .sync_err_count(sync_err_count), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Endpoint RAM: q reflects the address RL clock edges after it was presented.
  logic [7:0] mem [0:511];
  logic [7:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bif.buf_out_addr[8:0]];
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bif.buf_out_q = rd_pipe[RL-1];

  int errors = 0;
  int checks = 0;

  logic [7:0] wr_q [$];
  int first_wr, last_wr, arm_lat, max_after_af;
  bit timed_out, arm_early, arm_dropped, arm_after_ack;

  function automatic logic [7:0] filler(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  function automatic int order_bad(input int len);
    int bad = 0;
    for (int i = 0; i < len && i < wr_q.size(); i++)
      if (wr_q[i] !== mem[i]) bad++;
    return bad;
  endfunction

  // Presents one buffer of len bytes and plays the USB core / FIFO side,
  // recording every write and arm behaviour for the calling scenario.
  task automatic run_buf(input int len, input int ack_delay, input bit af_toggle, input int en_drop_at);
    int cyc = 0;
    int arm_cnt = 0;
    int after_af = 0;
    bit acked = 0, done = 0, arm_seen = 0, next_af;
    wr_q.delete();
    first_wr = -1; last_wr = -1; arm_lat = -1; max_after_af = 0;
    timed_out = 0; arm_early = 0; arm_dropped = 0; arm_after_ack = 0;
    @(negedge clk);
    bif.buf_out_len = 10'(len);
    bif.buf_out_hasdata = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (bif.ts_usb_writereq) begin
        wr_q.push_back(bif.ts_usb_data);
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (bif.ts_usb_almost_full) begin
          after_af++;
          if (after_af > max_after_af) max_after_af = after_af;
        end
      end
      if (acked) begin
        arm_after_ack = bif.buf_out_arm;
        bif.buf_out_arm_ack = 1'b0;
        done = 1;
      end else if (bif.buf_out_arm) begin
        if (!arm_seen) arm_lat = cyc;
        arm_seen = 1;
        if (wr_q.size() < len) arm_early = 1;
        arm_cnt++;
        if (arm_cnt >= ack_delay) begin
          bif.buf_out_arm_ack = 1'b1;
          bif.buf_out_hasdata = 1'b0;
          acked = 1;
        end
      end else if (arm_seen) begin
        arm_dropped = 1;
      end
      if (en_drop_at >= 0 && wr_q.size() >= en_drop_at) enable = 1'b0;
      if (af_toggle) begin
        next_af = ((cyc % 50) >= 45);
        if (next_af && !bif.ts_usb_almost_full) after_af = 0;
        bif.ts_usb_almost_full = next_af;
      end
      if (cyc >= 4000) begin
        timed_out = 1;
        done = 1;
      end
    end
    bif.ts_usb_almost_full = 1'b0;
    bif.buf_out_arm_ack = 1'b0;
    bif.buf_out_hasdata = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bif.buf_out_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bif.buf_out_addr); end
    checks++; if (bif.buf_out_arm !== 1'b0) begin errors++; $display("FAIL reset_arm: got %b want 0", bif.buf_out_arm); end
    checks++; if (bif.ts_usb_writereq !== 1'b0) begin errors++; $display("FAIL reset_writereq: got %b want 0", bif.ts_usb_writereq); end
    checks++; if (bif.ts_usb_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bif.ts_usb_data); end
    checks++; if (sync_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", sync_locked); end
    checks++; if (sync_err_count !== 16'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", sync_err_count); end
    checks++; if (byte_count !== 32'd0) begin errors++; $display("FAIL reset_bytecnt: got %0d want 0", byte_count); end
    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    mem[0] = 8'h47;
    for (int i = 1; i < 188; i++) mem[i] = 8'(i);
    run_buf(188, 3, 1'b0, -1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b want 0", timed_out); end
    checks++; if (wr_q.size() !== 188) begin errors++; $display("FAIL single_count: got %0d want 188", wr_q.size()); end
    checks++; if (order_bad(188) !== 0) begin errors++; $display("FAIL single_order: got %0d bad bytes want 0", order_bad(188)); end
    checks++; if (last_wr - first_wr + 1 !== 188) begin errors++; $display("FAIL single_consecutive: got span %0d want 188", last_wr - first_wr + 1); end
    checks++; if (arm_early !== 1'b0) begin errors++; $display("FAIL single_arm_early: got %b want 0", arm_early); end
    checks++; if (arm_dropped !== 1'b0) begin errors++; $display("FAIL single_arm_hold: got dropped=%b want 0", arm_dropped); end
    checks++; if (arm_after_ack !== 1'b0) begin errors++; $display("FAIL single_arm_after_ack: got %b want 0", arm_after_ack); end
    checks++; if (sync_locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %b want 1", sync_locked); end
    checks++; if (byte_count !== 32'd188) begin errors++; $display("FAIL single_bytecnt: got %0d want 188", byte_count); end
    checks++; if (sync_err_count !== 16'd0) begin errors++; $display("FAIL single_errcnt: got %0d want 0", sync_err_count); end
  endtask

  task automatic test_len_zero();
    run_buf(0, 1, 1'b0, -1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL len0_timeout: got %b want 0", timed_out); end
    checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL len0_writes: got %0d want 0", wr_q.size()); end
    checks++; if (arm_lat < 1 || arm_lat > 2) begin errors++; $display("FAIL len0_arm_latency: got %0d want 1..2", arm_lat); end
    checks++; if (arm_after_ack !== 1'b0) begin errors++; $display("FAIL len0_arm_after_ack: got %b want 0", arm_after_ack); end
    checks++; if (byte_count !== 32'd188) begin errors++; $display("FAIL len0_bytecnt: got %0d want 188", byte_count); end
  endtask

  // Stream of 1024 bytes with 0x47 at every 188-byte boundary, split over two buffers.
  task automatic test_back_to_back();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 512; i++) mem[i] = (((b * 512 + i) % 188) == 0) ? 8'h47 : filler(b * 512 + i);
      run_buf(512, 2, 1'b1, -1);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL b2b_timeout buf%0d: got %b want 0", b, timed_out); end
      checks++; if (wr_q.size() !== 512) begin errors++; $display("FAIL b2b_count buf%0d: got %0d want 512", b, wr_q.size()); end
      checks++; if (order_bad(512) !== 0) begin errors++; $display("FAIL b2b_order buf%0d: got %0d bad bytes want 0", b, order_bad(512)); end
      checks++; if (max_after_af > RL) begin errors++; $display("FAIL b2b_af_overrun buf%0d: got %0d writes want <=%0d", b, max_after_af, RL); end
      checks++; if (arm_early !== 1'b0) begin errors++; $display("FAIL b2b_arm_early buf%0d: got %b want 0", b, arm_early); end
    end
    checks++; if (sync_err_count !== 16'd0) begin errors++; $display("FAIL b2b_errcnt: got %0d want 0", sync_err_count); end
    checks++; if (sync_locked !== 1'b1) begin errors++; $display("FAIL b2b_locked: got %b want 1", sync_locked); end
    checks++; if (byte_count !== 32'd1212) begin errors++; $display("FAIL b2b_bytecnt: got %0d want 1212", byte_count); end
  endtask

  // Packet position is 84 here; the boundary falls at buffer offset 104.
  task automatic test_sync_err();
    for (int i = 0; i < 105; i++) mem[i] = filler(i);
    mem[104] = 8'h00;
    run_buf(105, 1, 1'b0, -1);
    checks++; if (order_bad(105) !== 0 || wr_q.size() !== 105) begin errors++; $display("FAIL syncerr_order: got %0d bytes %0d bad want 105 0", wr_q.size(), order_bad(105)); end
    checks++; if (sync_err_count !== 16'd1) begin errors++; $display("FAIL syncerr_errcnt: got %0d want 1", sync_err_count); end
    checks++; if (sync_locked !== 1'b0) begin errors++; $display("FAIL syncerr_unlocked: got %b want 0", sync_locked); end
    mem[0] = 8'h47;
    for (int i = 1; i < 188; i++) mem[i] = filler(i);
    run_buf(188, 1, 1'b0, -1);
    checks++; if (sync_locked !== 1'b1) begin errors++; $display("FAIL syncerr_relock: got %b want 1", sync_locked); end
    checks++; if (sync_err_count !== 16'd1) begin errors++; $display("FAIL syncerr_errcnt_after: got %0d want 1", sync_err_count); end
    checks++; if (byte_count !== 32'd1505) begin errors++; $display("FAIL syncerr_bytecnt: got %0d want 1505", byte_count); end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    int cyc = 0;
    bit arm_any = 0;
    for (int i = 0; i < 512; i++) mem[i] = ((i % 188) == 0) ? 8'h47 : filler(i + 1000);
    @(negedge clk);
    bif.buf_out_len = 10'd512;
    bif.buf_out_hasdata = 1'b1;
    while (cnt < 100 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bif.ts_usb_writereq) cnt++;
    end
    checks++; if (cnt !== 100) begin errors++; $display("FAIL rstmid_reach100: got %0d want 100", cnt); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bif.buf_out_addr !== 11'd0) begin errors++; $display("FAIL rstmid_addr: got %0d want 0", bif.buf_out_addr); end
    checks++; if (bif.ts_usb_writereq !== 1'b0 || bif.ts_usb_data !== 8'h00) begin errors++; $display("FAIL rstmid_write: got %b/%h want 0/00", bif.ts_usb_writereq, bif.ts_usb_data); end
    checks++; if (byte_count !== 32'd0 || sync_err_count !== 16'd0 || sync_locked !== 1'b0) begin errors++; $display("FAIL rstmid_status: got %0d/%0d/%b want 0/0/0", byte_count, sync_err_count, sync_locked); end
    repeat (3) begin
      @(negedge clk);
      if (bif.buf_out_arm) arm_any = 1;
    end
    checks++; if (arm_any !== 1'b0) begin errors++; $display("FAIL rstmid_no_arm: got %b want 0", arm_any); end
    reset = 1'b0;
    run_buf(512, 2, 1'b0, -1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got %b want 0", timed_out); end
    checks++; if (wr_q.size() !== 512 || order_bad(512) !== 0) begin errors++; $display("FAIL rstmid_reread: got %0d bytes %0d bad want 512 0", wr_q.size(), order_bad(512)); end
    checks++; if (byte_count !== 32'd512) begin errors++; $display("FAIL rstmid_bytecnt: got %0d want 512", byte_count); end
    checks++; if (sync_locked !== 1'b1 || sync_err_count !== 16'd0) begin errors++; $display("FAIL rstmid_sync: got %b/%0d want 1/0", sync_locked, sync_err_count); end
  endtask

  task automatic test_enable_drop();
    int extra = 0;
    for (int i = 0; i < 188; i++) mem[i] = filler(i + 77);
    run_buf(188, 2, 1'b0, 10);
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL endrop_enable_low: got %b want 0", enable); end
    checks++; if (timed_out !== 1'b0 || arm_after_ack !== 1'b0) begin errors++; $display("FAIL endrop_arm: got timeout=%b arm_after_ack=%b want 0 0", timed_out, arm_after_ack); end
    checks++; if (wr_q.size() !== 188 || order_bad(188) !== 0) begin errors++; $display("FAIL endrop_bytes: got %0d bytes %0d bad want 188 0", wr_q.size(), order_bad(188)); end
    checks++; if (byte_count !== 32'd700) begin errors++; $display("FAIL endrop_bytecnt: got %0d want 700", byte_count); end
    @(negedge clk);
    bif.buf_out_len = 10'd20;
    bif.buf_out_hasdata = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bif.ts_usb_writereq || bif.buf_out_arm) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL endrop_ignored: got %0d active cycles want 0", extra); end
    bif.buf_out_hasdata = 1'b0;
  endtask

  initial begin
    bif.buf_out_hasdata    = 1'b0;
    bif.buf_out_len        = 10'd0;
    bif.buf_out_arm_ack    = 1'b0;
    bif.ts_usb_almost_full = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    test_reset();
    test_single();
    test_len_zero();
    test_back_to_back();
    test_sync_err();
    test_reset_mid();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
